// File: rtl/neuron_sel_seq_if.sv
// Handshake and data bundle between a neuron sequencer and its neighbours.
// The master side drives go/data inputs; the slave side is the sequencer.
interface neuron_sel_seq_if #(
  parameter int unsigned WEIGHT_N   = 5,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 1
);
  localparam int unsigned BEATS  = (WEIGHT_N + LANES - 1) / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                             go_in_l;
  logic                             go_in_r;
  logic [DATA_WIDTH*WEIGHT_N-1:0]   data_in;
  logic [DATA_WIDTH*LANES-1:0]      data_out;
  logic [LANES-1:0]                 lane_valid;
  logic                             first_o;
  logic                             last_o;
  logic                             busy_o;
  logic [BEAT_W-1:0]                beat_idx;
  logic                             go_out_l;
  logic                             go_out_r;
  logic                             freeze_r;

  modport master (
    output go_in_l, go_in_r, data_in,
    input  data_out, lane_valid, first_o, last_o, busy_o, beat_idx,
    input  go_out_l, go_out_r, freeze_r
  );

  modport slave (
    input  go_in_l, go_in_r, data_in,
    output data_out, lane_valid, first_o, last_o, busy_o, beat_idx,
    output go_out_l, go_out_r, freeze_r
  );
endinterface

// File: rtl/neuron_sel_seq.sv
// Weight/input word sequencer for one neuron: walks WEIGHT_N packed words of
// data_in, LANES words per beat, and handshakes with left/right layers.
module neuron_sel_seq #(
  parameter int unsigned WEIGHT_N   = 5,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 1
) (
  input logic              clk,
  input logic              rst_n,
  neuron_sel_seq_if.slave  bus
);
  localparam int unsigned BEATS  = (WEIGHT_N + LANES - 1) / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DOUT_W = DATA_WIDTH * LANES;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              go_out_l_q, go_out_l_d;
  logic              go_out_r_q, go_out_r_d;
  logic              freeze_r_q, freeze_r_d;

  logic              busy;
  logic [DOUT_W-1:0] data_out_c;
  logic [LANES-1:0]  lane_valid_c;

  // Next-state: IDLE waits on left only; HOLD needs both neighbours; RUN ignores them.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    go_out_l_d = go_out_l_q;
    go_out_r_d = go_out_r_q;
    freeze_r_d = freeze_r_q;
    unique case (state_q)
      StIdle: begin
        if (bus.go_in_l) begin
          state_d    = StRun;
          beat_d     = '0;
          go_out_l_d = 1'b0;
          go_out_r_d = 1'b0;
          freeze_r_d = 1'b0;
        end
      end
      StRun: begin
        if (beat_q == LastBeat) begin
          state_d    = StHold;
          beat_d     = '0;
          go_out_l_d = 1'b1;
          go_out_r_d = 1'b1;
          freeze_r_d = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      StHold: begin
        if (bus.go_in_l && bus.go_in_r) begin
          state_d    = StRun;
          beat_d     = '0;
          go_out_l_d = 1'b0;
          go_out_r_d = 1'b0;
          freeze_r_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = '0;
      end
    endcase
  end

  // State registers; reset leaves the downstream accumulator frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      go_out_l_q <= 1'b0;
      go_out_r_q <= 1'b0;
      freeze_r_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      go_out_l_q <= go_out_l_d;
      go_out_r_q <= go_out_r_d;
      freeze_r_q <= freeze_r_d;
    end
  end

  assign busy = (state_q == StRun);

  // Lane mux: lanes past the last real word read as zero and are not valid.
  // Shifts instead of part-selects keep index widths independent of parameters.
  always_comb begin
    int unsigned idx;
    logic [DATA_WIDTH-1:0] word;
    data_out_c   = '0;
    lane_valid_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx  = int'(beat_q) * LANES + k;
      word = '0;
      if (idx < WEIGHT_N) begin
        word = DATA_WIDTH'(bus.data_in >> (idx * DATA_WIDTH));
        if (busy) begin
          lane_valid_c = lane_valid_c | (LANES'(1) << k);
        end
      end
      data_out_c = data_out_c | (DOUT_W'(word) << (k * DATA_WIDTH));
    end
  end

  assign bus.data_out   = data_out_c;
  assign bus.lane_valid = lane_valid_c;
  assign bus.busy_o     = busy;
  assign bus.first_o    = busy && (beat_q == '0);
  assign bus.last_o     = busy && (beat_q == LastBeat);
  assign bus.beat_idx   = beat_q;
  assign bus.go_out_l   = go_out_l_q;
  assign bus.go_out_r   = go_out_r_q;
  assign bus.freeze_r   = freeze_r_q;
endmodule

// File: tb/tb_neuron_sel_seq.sv
// Directed bench for neuron_sel_seq: three instances (W5/L1, W5/L2, W1/L1).
module tb_neuron_sel_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passes = 0;
  int   total = 0;

  always #5 clk = ~clk;

  neuron_sel_seq_if #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(1)) if_a ();
  neuron_sel_seq_if #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(2)) if_b ();
  neuron_sel_seq_if #(.WEIGHT_N(1), .DATA_WIDTH(16), .LANES(1)) if_c ();

  neuron_sel_seq #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  neuron_sel_seq #(.WEIGHT_N(5), .DATA_WIDTH(16), .LANES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  neuron_sel_seq #(.WEIGHT_N(1), .DATA_WIDTH(16), .LANES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] b_data [3];
    logic [1:0]  b_lv [3];
    b_data[0] = 32'h0002_0001;
    b_data[1] = 32'h0004_0003;
    b_data[2] = 32'h0000_0005;
    b_lv[0] = 2'b11;
    b_lv[1] = 2'b11;
    b_lv[2] = 2'b01;

    if_a.go_in_l = 0; if_a.go_in_r = 0;
    if_b.go_in_l = 0; if_b.go_in_r = 0;
    if_c.go_in_l = 0; if_c.go_in_r = 0;
    if_a.data_in = {16'd14, 16'd13, 16'd12, 16'd11, 16'd10};
    if_b.data_in = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    if_c.data_in = 16'd7;

    // Reset state
    tick(); tick();
    chk("rst_go_out_l", if_a.go_out_l, 0);
    chk("rst_go_out_r", if_a.go_out_r, 0);
    chk("rst_freeze_r", if_a.freeze_r, 1);
    chk("rst_busy", if_a.busy_o, 0);
    chk("rst_lane_valid", if_a.lane_valid, 0);
    chk("rst_first", if_a.first_o, 0);
    rst_n = 1'b1;
    tick();

    // W=5,L=1 pass; go_in_r alone in IDLE must not start
    if_a.go_in_r = 1;
    tick();
    chk("idle_ignores_r", if_a.busy_o, 0);
    if_a.go_in_r = 0;
    if_a.go_in_l = 1;
    tick();
    if_a.go_in_l = 0;
    chk("run_freeze_low", if_a.freeze_r, 0);
    for (int j = 0; j < 5; j++) begin
      chk("a_data", if_a.data_out, 64'(10 + j));
      chk("a_first", if_a.first_o, (j == 0));
      chk("a_last", if_a.last_o, (j == 4));
      chk("a_busy", if_a.busy_o, 1);
      chk("a_go_out_l_run", if_a.go_out_l, 0);
      tick();
    end
    chk("a_done_go_out_l", if_a.go_out_l, 1);
    chk("a_done_go_out_r", if_a.go_out_r, 1);
    chk("a_done_freeze", if_a.freeze_r, 1);
    chk("a_done_busy", if_a.busy_o, 0);

    // HOLD needs both neighbours
    if_a.go_in_l = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("hold_l_only_busy", if_a.busy_o, 0);
      chk("hold_l_only_go", if_a.go_out_l, 1);
    end
    if_a.go_in_r = 1;
    tick();
    if_a.go_in_l = 0; if_a.go_in_r = 0;
    chk("rerun_busy", if_a.busy_o, 1);
    chk("rerun_freeze", if_a.freeze_r, 0);
    chk("rerun_go_out_l", if_a.go_out_l, 0);
    chk("rerun_go_out_r", if_a.go_out_r, 0);
    chk("rerun_data0", if_a.data_out, 10);

    // Toggling go inputs during RUN has no effect
    for (int j = 1; j < 5; j++) begin
      if_a.go_in_l = logic'(j % 2);
      if_a.go_in_r = 1;
      tick();
      chk("toggle_data", if_a.data_out, 64'(10 + j));
      chk("toggle_beat", if_a.beat_idx, 64'(j));
    end
    if_a.go_in_l = 0; if_a.go_in_r = 0;
    tick();
    chk("toggle_done_busy", if_a.busy_o, 0);
    chk("toggle_done_go", if_a.go_out_r, 1);

    // W=5,L=2 beats
    if_b.go_in_l = 1;
    tick();
    if_b.go_in_l = 0;
    for (int j = 0; j < 3; j++) begin
      chk("b_data", if_b.data_out, b_data[j]);
      chk("b_lane_valid", if_b.lane_valid, b_lv[j]);
      chk("b_first", if_b.first_o, (j == 0));
      chk("b_last", if_b.last_o, (j == 2));
      tick();
    end
    chk("b_done_go_out_l", if_b.go_out_l, 1);
    chk("b_done_freeze", if_b.freeze_r, 1);
    chk("b_done_lane_valid", if_b.lane_valid, 0);

    // Reset mid-run at beat 2
    if_a.go_in_l = 1; if_a.go_in_r = 1;
    tick();
    if_a.go_in_l = 0; if_a.go_in_r = 0;
    tick(); tick();
    chk("mid_beat2_data", if_a.data_out, 12);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", if_a.busy_o, 0);
    chk("mid_rst_freeze", if_a.freeze_r, 1);
    chk("mid_rst_lane_valid", if_a.lane_valid, 0);
    chk("mid_rst_beat", if_a.beat_idx, 0);
    chk("mid_rst_b_go_out_l", if_b.go_out_l, 0);
    chk("mid_rst_b_go_out_r", if_b.go_out_r, 0);
    tick();
    rst_n = 1'b1;
    if_a.go_in_l = 1;
    tick();
    if_a.go_in_l = 0;
    chk("restart_busy", if_a.busy_o, 1);
    chk("restart_data0", if_a.data_out, 10);
    tick();
    chk("restart_data1", if_a.data_out, 11);

    // W=1: single beat is both first and last
    if_c.go_in_l = 1;
    tick();
    if_c.go_in_l = 0;
    chk("c_busy", if_c.busy_o, 1);
    chk("c_first", if_c.first_o, 1);
    chk("c_last", if_c.last_o, 1);
    chk("c_data", if_c.data_out, 7);
    chk("c_lane_valid", if_c.lane_valid, 1);
    tick();
    chk("c_done_busy", if_c.busy_o, 0);
    chk("c_done_go_out_l", if_c.go_out_l, 1);
    chk("c_done_freeze", if_c.freeze_r, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
